// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: one fetch per execute slot over a
// req/ack memory handshake, next-PC selection and supervisor-gated interrupt request.
module pc_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic [2:0]  pcsel,
  input  logic [31:0] jt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        irq_in,
  output logic        irq,
  output logic [1:0]  dbg_state,
  output logic        dbg_irq_pend
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] next_pc;
  logic [30:0] br_off;
  logic [30:0] br_sum;
  logic        irq_sync1;
  logic        irq_s;
  logic        irq_pend;
  logic        unused_jt;

  // Handshake: imem_req is held high with a constant imem_addr for every FETCH
  // cycle; the transfer completes on the rising edge where imem_req and imem_ack
  // are both high. imem_rdata and imem_ack are ignored at any other time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = EXEC;
      EXEC:    state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req     = (state_q == FETCH);
  assign instr_valid  = (state_q == EXEC);
  assign dbg_state    = state_q;
  assign dbg_irq_pend = irq_pend;

  assign imem_addr = {pc[31:2], 2'b00};
  assign pc_plus4  = {pc[31], pc[30:0] + 31'd4};
  assign op        = instr[31:26];

  // Offsets are word counts; the sum wraps inside bits 30:0 so the supervisor
  // bit is never touched by a carry.
  assign br_off = {{13{instr[15]}}, instr[15:0], 2'b00};
  assign br_sum = pc_plus4[30:0] + br_off;

  always_comb begin
    next_pc = ILLOP_VEC;
    case (pcsel)
      3'd0:    next_pc = pc_plus4;
      3'd1:    next_pc = {pc[31], br_sum};
      3'd2:    next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
      3'd4:    next_pc = XADR_VEC;
      default: next_pc = ILLOP_VEC;
    endcase
  end

  assign unused_jt = &{1'b0, jt[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_VEC;
      instr <= 32'd0;
    end else begin
      if (state_q == FETCH && imem_ack) instr <= imem_rdata;
      if (state_q == EXEC)              pc    <= next_pc;
    end
  end

  // A still-asserted synchronised line wins over the clear so a level that has
  // not been dropped by the device keeps the request pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_sync1 <= 1'b0;
      irq_s     <= 1'b0;
      irq_pend  <= 1'b0;
    end else begin
      irq_sync1 <= irq_in;
      irq_s     <= irq_sync1;
      if (irq_s)                         irq_pend <= 1'b1;
      else if (state_q == EXEC && irq)   irq_pend <= 1'b0;
    end
  end

  assign irq = instr_valid & irq_pend & ~pc[31];

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a behavioural instruction memory drives req/ack and
// each scenario task checks fetch timing, next-PC selection and interrupt gating.
module tb_pc_fetch;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_FETCH   = 2'd1;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [2:0]  pcsel;
  logic [31:0] jt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq_in;
  logic        irq;
  logic [1:0]  dbg_state;
  logic        dbg_irq_pend;

  int checks   = 0;
  int failures = 0;

  int          rc;
  logic [31:0] fa;
  logic        as;
  logic [31:0] ep;
  logic [5:0]  eo;
  logic        ev;
  logic        ei;

  pc_fetch #(
    .RESET_VEC(RESET_VEC),
    .ILLOP_VEC(ILLOP_VEC),
    .XADR_VEC (XADR_VEC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .pcsel       (pcsel),
    .jt          (jt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .irq_in      (irq_in),
    .irq         (irq),
    .dbg_state   (dbg_state),
    .dbg_irq_pend(dbg_irq_pend)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Memory driver: waits for a request, acks after `waits` cycles, then supplies
  // pcsel/jt during EXEC. All driving and sampling happens on falling edges.
  task automatic run_instr(input int waits, input logic [31:0] word,
                           input logic [2:0] sel, input logic [31:0] jtv,
                           output int req_cycles, output logic [31:0] fetch_addr,
                           output logic addr_stable, output logic [31:0] exec_pc,
                           output logic [5:0] exec_op, output logic exec_valid,
                           output logic exec_irq);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL fetch_timeout imem_req=%b required=1", imem_req);
    end
    fetch_addr  = imem_addr;
    addr_stable = 1'b1;
    req_cycles  = 0;
    for (int i = 0; i <= waits; i++) begin
      if (imem_addr !== fetch_addr) addr_stable = 1'b0;
      if (imem_req === 1'b1) req_cycles++;
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? word : $urandom();
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    exec_pc    = pc;
    exec_op    = op;
    exec_valid = instr_valid;
    exec_irq   = irq;
    pcsel      = sel;
    jt         = jtv;
    @(negedge clk);
    pcsel = 3'd0;
    jt    = $urandom();
  endtask

  task test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (pc !== RESET_VEC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, RESET_VEC); end
    checks++; if (instr !== 32'd0 || op !== 6'd0) begin failures++; $display("FAIL rst_instr got=%h/%h exp=0", instr, op); end
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL rst_ctrl got v=%b r=%b i=%b exp=000", instr_valid, imem_req, irq); end
    checks++; if (imem_addr !== RESET_VEC || pc_plus4 !== 32'h8000_0004) begin failures++; $display("FAIL rst_addr got=%h/%h exp=80000000/80000004", imem_addr, pc_plus4); end
    checks++; if (dbg_irq_pend !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", dbg_irq_pend); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL req_before_edge got=%b exp=0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || dbg_state !== S_FETCH) begin failures++; $display("FAIL req_first got=%b st=%0d exp=1 st=1", imem_req, dbg_state); end
    run_instr(0, 32'hC0A3_0005, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (rc !== 1 || fa !== 32'h8000_0000) begin failures++; $display("FAIL zw_fetch got cyc=%0d addr=%h exp cyc=1 addr=80000000", rc, fa); end
    checks++; if (ev !== 1'b1 || eo !== 6'h30) begin failures++; $display("FAIL zw_exec got v=%b op=%h exp v=1 op=30", ev, eo); end
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL zw_single got v=%b r=%b exp v=0 r=1", instr_valid, imem_req); end
    checks++; if (imem_addr !== 32'h8000_0004) begin failures++; $display("FAIL zw_next_addr got=%h exp=80000004", imem_addr); end
  endtask

  task test_wait_states;
    run_instr(3, 32'h1234_5678, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (rc !== 4 || as !== 1'b1 || fa !== 32'h8000_0004) begin failures++; $display("FAIL ws_req got cyc=%0d stable=%b addr=%h exp 4/1/80000004", rc, as, fa); end
    checks++; if (ep !== 32'h8000_0004 || ev !== 1'b1 || eo !== 6'h04) begin failures++; $display("FAIL ws_exec got pc=%h v=%b op=%h exp 80000004/1/04", ep, ev, eo); end
    checks++; if (pc !== 32'h8000_0008 || instr !== 32'h1234_5678 || instr_valid !== 1'b0) begin failures++; $display("FAIL ws_after got pc=%h instr=%h v=%b exp 80000008/12345678/0", pc, instr, instr_valid); end
  endtask

  task test_jmp;
    run_instr(0, 32'h0000_0000, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    run_instr(1, 32'h0000_0000, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (pc !== 32'h8000_0010) begin failures++; $display("FAIL seq_pc got=%h exp=80000010", pc); end
    run_instr(0, 32'h6C00_0000, 3'd2, 32'h0000_0203, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ep !== 32'h8000_0010 || pc !== 32'h0000_0200) begin failures++; $display("FAIL jmp_to_user got from=%h to=%h exp 80000010->00000200", ep, pc); end
    run_instr(0, 32'h6C00_0000, 3'd2, 32'h0000_0040, rc, fa, as, ep, eo, ev, ei);
    run_instr(0, 32'h6C00_0000, 3'd2, 32'h8000_0100, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ep !== 32'h0000_0040 || pc !== 32'h0000_0100) begin failures++; $display("FAIL jmp_no_set got from=%h to=%h exp 00000040->00000100", ep, pc); end
  endtask

  task test_branch;
    run_instr(0, 32'h7400_FFFE, 3'd1, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (pc !== 32'h0000_00FC) begin failures++; $display("FAIL br_back got=%h exp=000000fc", pc); end
    run_instr(0, 32'h6C00_0000, 3'd2, 32'h7FFF_FFFC, rc, fa, as, ep, eo, ev, ei);
    checks++; if (pc !== 32'h7FFF_FFFC || pc_plus4 !== 32'h0000_0000) begin failures++; $display("FAIL br_edge_pc got pc=%h p4=%h exp 7ffffffc/00000000", pc, pc_plus4); end
    run_instr(2, 32'h7400_0000, 3'd1, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (pc !== 32'h0000_0000) begin failures++; $display("FAIL br_wrap got=%h exp=00000000", pc); end
  endtask

  task test_irq;
    irq_in = 1'b1;
    repeat (3) @(negedge clk);
    irq_in = 1'b0;
    checks++; if (dbg_irq_pend !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL irq_pend_fetch got pend=%b irq=%b exp 1/0", dbg_irq_pend, irq); end
    repeat (3) @(negedge clk);
    run_instr(0, 32'h0000_0000, 3'd4, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ei !== 1'b1) begin failures++; $display("FAIL irq_user got=%b exp=1", ei); end
    checks++; if (pc !== XADR_VEC || dbg_irq_pend !== 1'b0) begin failures++; $display("FAIL irq_taken got pc=%h pend=%b exp 80000008/0", pc, dbg_irq_pend); end
    irq_in = 1'b1;
    repeat (3) @(negedge clk);
    irq_in = 1'b0;
    repeat (3) @(negedge clk);
    run_instr(0, 32'h0000_0000, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ei !== 1'b0 || dbg_irq_pend !== 1'b1 || pc !== 32'h8000_000C) begin failures++; $display("FAIL irq_super got irq=%b pend=%b pc=%h exp 0/1/8000000c", ei, dbg_irq_pend, pc); end
    run_instr(0, 32'h6C00_0000, 3'd2, 32'h0000_0300, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ei !== 1'b0 || pc !== 32'h0000_0300) begin failures++; $display("FAIL irq_jmp got irq=%b pc=%h exp 0/00000300", ei, pc); end
    run_instr(0, 32'h0000_0000, 3'd4, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ei !== 1'b1 || pc !== XADR_VEC || dbg_irq_pend !== 1'b0) begin failures++; $display("FAIL irq_after_jmp got irq=%b pc=%h pend=%b exp 1/80000008/0", ei, pc, dbg_irq_pend); end
  endtask

  task test_illop_and_reset;
    run_instr(0, 32'hFC00_0000, 3'd6, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (pc !== ILLOP_VEC) begin failures++; $display("FAIL illop_sel6 got=%h exp=80000004", pc); end
    run_instr(0, 32'hFC00_0000, 3'd3, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (ep !== ILLOP_VEC || pc !== ILLOP_VEC) begin failures++; $display("FAIL illop_sel3 got from=%h to=%h exp 80000004", ep, pc); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got req=%b exp=1", imem_req); end
    reset_n = 1'b0;
    #1;
    checks++; if (pc !== RESET_VEC || instr !== 32'd0 || dbg_state !== S_IDLE || imem_req !== 1'b0) begin failures++; $display("FAIL rst_mid got pc=%h instr=%h st=%0d req=%b exp 80000000/0/0/0", pc, instr, dbg_state, imem_req); end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (dbg_state !== S_FETCH || instr !== 32'd0 || pc !== RESET_VEC) begin failures++; $display("FAIL late_ack got st=%0d instr=%h pc=%h exp 1/0/80000000", dbg_state, instr, pc); end
    run_instr(0, 32'h0C00_0001, 3'd0, 32'd0, rc, fa, as, ep, eo, ev, ei);
    checks++; if (fa !== RESET_VEC || eo !== 6'h03 || pc !== 32'h8000_0004) begin failures++; $display("FAIL post_rst got addr=%h op=%h pc=%h exp 80000000/03/80000004", fa, eo, pc); end
  endtask

  initial begin
    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    pcsel      = 3'd0;
    jt         = 32'd0;
    irq_in     = 1'b0;
    @(negedge clk);
    test_reset();
    test_wait_states();
    test_jmp();
    test_branch();
    test_irq();
    test_illop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
